aes_shift_rows_pipe: RTL and testbench
======================================

AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, state columns (Rijndael Nb); legal values 4, 6, 8; any other value SHALL fail elaboration.
REQ-002 SHALL derive W = 32*NB, the state width in bits.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all registers.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: input beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-007 SHALL have port in_dir, input, 1 bit: 0 selects forward ShiftRows, 1 selects inverse.
REQ-008 SHALL have port in_data, input, [0:W-1]: state, byte k at bits [8k +: 8], column-major (k = 4c + r).
REQ-009 SHALL have port out_valid, output, 1 bit: result beat offered.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_data, output, [0:W-1]: shifted state, same layout as in_data.
REQ-012 SHALL have port out_dir, output, 1 bit: in_dir of the beat on out_data.

Function
REQ-013 SHALL use row offsets off_r = {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-014 Forward SHALL compute out[r][c] = in[r][(c + off_r) mod NB]; inverse SHALL compute out[r][c] = in[r][(c - off_r) mod NB].
REQ-015 SHALL accept a beat on a rising edge where in_valid && in_ready, and complete a beat where out_valid && out_ready.
REQ-016 SHALL present a beat accepted at edge N on out_data/out_dir with out_valid=1 immediately after edge N+1's predecessor, i.e. one cycle of latency, registered outputs only.
REQ-017 SHALL hold two storage slots, an output register and a skid register; in_ready SHALL be a registered signal equal to "skid empty".
REQ-018 When the output register is empty or completing this edge, an accepted beat SHALL load the output register; otherwise it SHALL load the skid register.
REQ-019 On output completion with the skid full, the skid contents SHALL move to the output register, and in_ready SHALL return to 1 on the next cycle.
REQ-020 SHALL sustain one beat per cycle while out_ready=1; beat order and direction SHALL be preserved exactly; no beat SHALL be dropped or duplicated.
REQ-021 out_data/out_dir SHALL remain stable while out_valid && !out_ready.
REQ-022 Simultaneous accept and complete SHALL be processed in the same edge without a bubble.

Reset
REQ-023 On reset=1 at a rising edge, the block SHALL clear out_valid to 0, out_data to 0, out_dir to 0, the skid to empty, and in_ready to 1; in-flight beats SHALL be discarded.
REQ-024 While reset=1, the block SHALL complete no transfers; reset SHALL take priority over all handshakes, including mid-stall.

Configuration
REQ-025 With macro AES_SHIFT_ROWS_CNT_EN defined, the block SHALL add output blk_cnt [15:0], counting completed output beats and wrapping from 16'hFFFF to 0, cleared by reset.
REQ-026 Without AES_SHIFT_ROWS_CNT_EN, blk_cnt and its counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-027 NB=4, inverse, in bytes 00..0F, out_ready=1 -> out bytes 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, out_dir=1, one cycle later.
REQ-028 NB=4, forward, bytes 00..0F -> 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; feeding that result back inverse -> 00..0F.
REQ-029 NB=8, forward, bytes 00..1F -> out bytes 0..3 = 00 05 0E 13; inverse of the result returns 00..1F.
REQ-030 Back-to-back beats A,B,C with out_ready held 0 for 3 cycles -> A held stable, B in skid, in_ready=0, C not accepted; then out_ready=1 -> A,B,C emitted on consecutive cycles.
REQ-031 Reset asserted with two beats buffered -> next cycle out_valid=0, in_ready=1, and no stale beat emitted after release; with AES_SHIFT_ROWS_CNT_EN defined, blk_cnt=0.
REQ-032 With AES_SHIFT_ROWS_CNT_EN defined, 65537 completed beats -> blk_cnt=1.

Source files
------------

// File: rtl/aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// aes_shift_rows_pipe
//
// Purpose:
//   Rijndael ShiftRows / InvShiftRows for a state of NB 32-bit columns (NB can
//   be 4, 6 or 8), wrapped in a valid/ready pipeline stage. The stage has one
//   cycle of latency and registered outputs. A skid register lets it sustain
//   one beat per cycle without in_ready depending combinationally on
//   out_ready.
//
// Parameters:
//   NB        - state columns (4, 6 or 8); any other value fails elaboration
//   W         - derived state width, 32*NB bits
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset
//   in_valid  - input beat offered
//   in_ready  - block can accept a beat (registered, equals "skid empty")
//   in_dir    - 0 = forward ShiftRows, 1 = inverse
//   in_data   - state, byte k at [8k +: 8], column-major with k = 4c + r
//   out_valid - result beat offered
//   out_ready - downstream accepts the result
//   out_data  - shifted state, same layout as in_data
//   out_dir   - in_dir of the beat currently on out_data
//   blk_cnt   - completed output beats, wraps at 16 bits
//               (present only when AES_SHIFT_ROWS_CNT_EN is defined)
//
// Optional feature macro: AES_SHIFT_ROWS_CNT_EN
// ---------------------------------------------------------------------------
module aes_shift_rows_pipe #(
    parameter  int NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [0:W-1] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] out_data,
    output logic         out_dir
`ifdef AES_SHIFT_ROWS_CNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    // Reject unsupported block sizes at elaboration time.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Row rotation amounts. Rijndael uses larger offsets for rows 2 and 3
    // when the state is 256 bits wide.
    function automatic int row_off(input int r);
        int off;
        off = r;
        if (NB == 8) begin
            if (r == 2) off = 3;
            if (r == 3) off = 4;
        end
        return off;
    endfunction

    // out[r][c] = in[r][(c +/- off_r) mod NB]. Byte (r, c) is at index 4c + r.
    function automatic logic [0:W-1] shift_rows(input logic [0:W-1] s,
                                                input logic         inv);
        logic [0:W-1] res;
        int           src;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - row_off(r) + NB) % NB;
                else     src = (c + row_off(r)) % NB;
                res[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
            end
        end
        return res;
    endfunction

    // Output register slot.
    logic         out_valid_q, out_valid_d;
    logic [0:W-1] out_data_q,  out_data_d;
    logic         out_dir_q,   out_dir_d;

    // Skid register slot. It is only loaded while the output slot is full
    // and stalled.
    logic         skid_valid_q, skid_valid_d;
    logic [0:W-1] skid_data_q,  skid_data_d;
    logic         skid_dir_q,   skid_dir_d;

    logic         in_ready_q, in_ready_d;

    logic [0:W-1] shifted;
    logic         accept;
    logic         complete;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the if/else chain can leave one unassigned and
        // infer a latch.
        shifted      = shift_rows(in_data, in_dir);
        accept       = in_valid && in_ready_q;
        complete     = out_valid_q && out_ready;

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_dir_d    = out_dir_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_dir_d   = skid_dir_q;

        // in_ready_q is low whenever the skid is full, so accept and
        // skid_valid_q are never both set. That keeps the priority chain short.
        if (skid_valid_q && complete) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_dir_d    = skid_dir_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!out_valid_q || complete)) begin
            // Output slot is free or freeing this edge: no bubble.
            out_valid_d  = 1'b1;
            out_data_d   = shifted;
            out_dir_d    = in_dir;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = shifted;
            skid_dir_d   = in_dir;
        end else if (complete) begin
            out_valid_d  = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_dir_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_dir_q    <= out_dir_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // NOTE: the skid payload is not reset. skid_valid_q qualifies it, and
    // leaving the wide data register out of reset keeps the reset fan-out
    // down.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_dir_q  <= skid_dir_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dir   = out_dir_q;

`ifdef AES_SHIFT_ROWS_CNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    // Wraps from 16'hFFFF to 0 through natural overflow.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (complete) blk_cnt_d = blk_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) blk_cnt_q <= '0;
        else       blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_shift_rows_pipe
//
// Purpose:
//   Self-checking bench for aes_shift_rows_pipe. It uses table-driven directed
//   vectors for NB=4 and NB=8, plus hand-written sequences for skid/stall
//   behaviour, reset while buffered, and (when AES_SHIFT_ROWS_CNT_EN is
//   defined) the completed-beat counter wrap.
// ---------------------------------------------------------------------------
module tb_aes_shift_rows_pipe;

    logic clk;
    logic reset;

    // NB = 4 instance
    logic         in_valid4, in_ready4, in_dir4;
    logic [0:127] in_data4;
    logic         out_valid4, out_ready4, out_dir4;
    logic [0:127] out_data4;

    // NB = 8 instance
    logic         in_valid8, in_ready8, in_dir8;
    logic [0:255] in_data8;
    logic         out_valid8, out_ready8, out_dir8;
    logic [0:255] out_data8;

`ifdef AES_SHIFT_ROWS_CNT_EN
    logic [15:0] blk_cnt4, blk_cnt8;
`endif

    aes_shift_rows_pipe #(.NB(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_dir    (in_dir4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_dir   (out_dir4)
`ifdef AES_SHIFT_ROWS_CNT_EN
        ,
        .blk_cnt   (blk_cnt4)
`endif
    );

    aes_shift_rows_pipe #(.NB(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_dir    (in_dir8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_dir   (out_dir8)
`ifdef AES_SHIFT_ROWS_CNT_EN
        ,
        .blk_cnt   (blk_cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        name;
        logic         dir;
        logic [0:127] din;
        logic [0:127] exp;
    } vec4_t;

    typedef struct {
        string        name;
        logic         dir;
        logic [0:255] din;
        logic [0:255] exp;
    } vec8_t;

    // Hand-computed vectors. Leftmost literal byte is byte 0.
    localparam logic [0:127] SEQ16     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] SEQ16_FWD = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [0:127] SEQ16_INV = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [0:127] A0_16     = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    localparam logic [0:127] A0_FWD    = 128'ha0a5aaafa4a9aea3a8ada2a7aca1a6ab;
    localparam logic [0:127] A0_INV    = 128'ha0adaaa7a4a1aeaba8a5a2afaca9a6a3;

    localparam logic [0:255] SEQ32 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:255] SEQ32_FWD =
        256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    vec4_t v4 [5];
    vec8_t v8 [2];

    initial begin
        v4[0] = '{"nb4_fwd_seq",    1'b0, SEQ16,     SEQ16_FWD};
        v4[1] = '{"nb4_inv_seq",    1'b1, SEQ16,     SEQ16_INV};
        v4[2] = '{"nb4_inv_of_fwd", 1'b1, SEQ16_FWD, SEQ16};
        v4[3] = '{"nb4_fwd_a0",     1'b0, A0_16,     A0_FWD};
        v4[4] = '{"nb4_inv_a0",     1'b1, A0_16,     A0_INV};
        v8[0] = '{"nb8_fwd_seq",    1'b0, SEQ32,     SEQ32_FWD};
        v8[1] = '{"nb8_inv_of_fwd", 1'b1, SEQ32_FWD, SEQ32};

        reset      = 1'b1;
        in_valid4  = 1'b0; in_dir4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        in_valid8  = 1'b0; in_dir8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        step();
        step();

        // Reset state
        check("rst_out_valid4", out_valid4, 1'b0);
        check("rst_in_ready4",  in_ready4,  1'b1);
        check("rst_out_data4",  out_data4,  '0);
        check("rst_out_dir4",   out_dir4,   1'b0);
        check("rst_out_valid8", out_valid8, 1'b0);
        check("rst_in_ready8",  in_ready8,  1'b1);
        reset = 1'b0;
        step();

        // Single beats, out_ready held high
        for (int i = 0; i < 5; i++) begin
            in_valid4 = 1'b1; in_dir4 = v4[i].dir; in_data4 = v4[i].din;
            step();
            in_valid4 = 1'b0;
            check({v4[i].name, "_valid"}, out_valid4, 1'b1);
            check({v4[i].name, "_data"},  out_data4,  v4[i].exp);
            check({v4[i].name, "_dir"},   out_dir4,   v4[i].dir);
            step();
            check({v4[i].name, "_drain"}, out_valid4, 1'b0);
        end

        for (int i = 0; i < 2; i++) begin
            in_valid8 = 1'b1; in_dir8 = v8[i].dir; in_data8 = v8[i].din;
            step();
            in_valid8 = 1'b0;
            check({v8[i].name, "_valid"}, out_valid8, 1'b1);
            check({v8[i].name, "_data"},  out_data8,  v8[i].exp);
            check({v8[i].name, "_dir"},   out_dir8,   v8[i].dir);
            step();
        end

        // Stall with three beats A, B, C offered back to back
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; in_dir4 = 1'b0; in_data4 = SEQ16;      // A
        step();
        in_dir4 = 1'b1; in_data4 = SEQ16;                        // B
        step();
        check("stall_in_ready_lo", in_ready4, 1'b0);
        check("stall_a_held",      out_data4, SEQ16_FWD);
        in_dir4 = 1'b0; in_data4 = A0_16;                        // C
        step();
        check("stall_c_refused",   in_ready4, 1'b0);
        check("stall_a_stable",    out_data4, SEQ16_FWD);
        check("stall_a_dir",       out_dir4,  1'b0);
        check("stall_valid",       out_valid4, 1'b1);
        out_ready4 = 1'b1;
        step();                       // A completes, B moves up
        check("drain_b_valid", out_valid4, 1'b1);
        check("drain_b_data",  out_data4,  SEQ16_INV);
        check("drain_b_dir",   out_dir4,   1'b1);
        check("drain_ready_hi", in_ready4, 1'b1);
        step();                       // B completes, C accepted and loaded
        in_valid4 = 1'b0;
        check("drain_c_valid", out_valid4, 1'b1);
        check("drain_c_data",  out_data4,  A0_FWD);
        check("drain_c_dir",   out_dir4,   1'b0);
        step();
        check("drain_empty",   out_valid4, 1'b0);

        // Reset with two beats buffered
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; in_dir4 = 1'b0; in_data4 = SEQ16;
        step();
        in_data4 = A0_16;
        step();
        in_valid4 = 1'b0;
        check("buf2_in_ready", in_ready4, 1'b0);
        reset = 1'b1;
        step();
        check("rst2_out_valid", out_valid4, 1'b0);
        check("rst2_in_ready",  in_ready4,  1'b1);
        check("rst2_out_data",  out_data4,  '0);
`ifdef AES_SHIFT_ROWS_CNT_EN
        check("rst2_blk_cnt",   blk_cnt4,   16'd0);
`endif
        reset = 1'b0;
        out_ready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_stale_beat", out_valid4, 1'b0);
        end

`ifdef AES_SHIFT_ROWS_CNT_EN
        // 65537 completed beats wrap the counter to 1
        in_valid4 = 1'b1; in_dir4 = 1'b0; in_data4 = SEQ16;
        repeat (65537) step();
        in_valid4 = 1'b0;
        step();
        check("blk_cnt_wrap", blk_cnt4, 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
